// File: rtl/accum_alu_seq_if.sv
// Command/result bundle between a command source and the accumulator ALU.
interface accum_alu_seq_if #(
  parameter int W = 8
) ();
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_load;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_b;
  logic [W-1:0] acc;
  logic         carry;
  logic         res_valid;
  logic         busy;

  // Command source side
  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_b,
    input  cmd_ready, acc, carry, res_valid, busy
  );

  // Accumulator ALU side
  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_b,
    output cmd_ready, acc, carry, res_valid, busy
  );
endinterface

// File: rtl/accum_alu_seq.sv
// Sequential accumulator front-end for the 8-bit lab ALU operation set.
// Logic ops, add and load finish at the accept edge; the two popcount ops
// walk a shadow copy of the operands one bit per cycle.
module accum_alu_seq #(
  parameter int W = 8
) (
  input logic           clk,
  input logic           rst,
  accum_alu_seq_if.slave bus
);
  localparam int IW = $clog2(2 * W);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state;
  logic [W-1:0]     accum;
  logic             carry_bit;
  logic             res_pulse;
  logic             ready;
  logic [2*W-1:0]   shadow;
  logic [W-1:0]     cnt;
  logic [IW-1:0]    bitidx;
  logic [IW-1:0]    last_idx;

  logic             accept;
  logic             serial_op;
  logic [W:0]       sum;
  logic [W-1:0]     alu_res;
  logic             alu_carry;
  logic [W-1:0]     cnt_next;

  assign accept    = bus.cmd_valid && ready;
  assign serial_op = (bus.cmd_op[2:1] == 2'b11);
  assign sum       = {1'b0, accum} + {1'b0, bus.cmd_b};
  assign cnt_next  = cnt + {{(W-1){1'b0}}, shadow[bitidx]};

  // Single-cycle result for ops 0-5; serial ops never use this path
  always_comb begin
    alu_res   = accum;
    alu_carry = 1'b0;
    case (bus.cmd_op)
      3'd0: alu_res = ~accum | bus.cmd_b;
      3'd1: alu_res = accum | ~bus.cmd_b;
      3'd2: alu_res = ~accum;
      3'd3: alu_res = accum & bus.cmd_b;
      3'd4: begin
        alu_res   = sum[W-1:0];
        alu_carry = sum[W];
      end
      3'd5: alu_res = ~(accum | bus.cmd_b);
      default: begin
        alu_res   = accum;
        alu_carry = 1'b0;
      end
    endcase
  end

  // Command acceptance, serial popcount scan and result write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      accum     <= {W{1'b0}};
      carry_bit <= 1'b0;
      res_pulse <= 1'b0;
      ready     <= 1'b1;
      shadow    <= {(2*W){1'b0}};
      cnt       <= {W{1'b0}};
      bitidx    <= {IW{1'b0}};
      last_idx  <= {IW{1'b0}};
    end else begin
      res_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.cmd_load) begin
              accum     <= bus.cmd_b;
              carry_bit <= 1'b0;
              res_pulse <= 1'b1;
            end else if (serial_op) begin
              // op 7 scans {B,A}; op 6 scans only A (upper half zeroed)
              if (bus.cmd_op[0]) begin
                shadow   <= {bus.cmd_b, accum};
                last_idx <= IW'(2 * W - 1);
              end else begin
                shadow   <= {{W{1'b0}}, accum};
                last_idx <= IW'(W - 1);
              end
              cnt    <= {W{1'b0}};
              bitidx <= {IW{1'b0}};
              state  <= SCAN;
              ready  <= 1'b0;
            end else begin
              accum     <= alu_res;
              carry_bit <= alu_carry;
              res_pulse <= 1'b1;
            end
          end
        end
        SCAN: begin
          cnt    <= cnt_next;
          bitidx <= bitidx + IW'(1);
          if (bitidx == last_idx) begin
            accum     <= cnt_next;
            carry_bit <= 1'b0;
            res_pulse <= 1'b1;
            ready     <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.acc       = accum;
  assign bus.carry     = carry_bit;
  assign bus.res_valid = res_pulse;
  assign bus.cmd_ready = ready;
  assign bus.busy      = ~ready;
endmodule

// File: tb/tb_accum_alu_seq.sv
// Directed bench for accum_alu_seq with a result scoreboard.
module tb_accum_alu_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [W:0] exp_q[$];
  logic [W-1:0] model_acc = '0;

  accum_alu_seq_if #(.W(W)) bus ();

  accum_alu_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic load, input logic [2:0] op);
    logic [W:0] r;
    if (load) return {1'b0, b};
    case (op)
      3'd0: r = {1'b0, (~a) | b};
      3'd1: r = {1'b0, a | (~b)};
      3'd2: r = {1'b0, ~a};
      3'd3: r = {1'b0, a & b};
      3'd4: r = {1'b0, a} + {1'b0, b};
      3'd5: r = {1'b0, ~(a | b)};
      3'd6: r = (W+1)'($countones(a));
      default: r = (W+1)'($countones(a) + $countones(b));
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accept edge
  task automatic send(input logic load, input logic [2:0] op, input logic [W-1:0] b);
    int n;
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = load;
    bus.cmd_op    = op;
    bus.cmd_b     = b;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    exp_q.push_back(model(model_acc, b, load, op));
    model_acc = exp_q[$][W-1:0];
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Scoreboard: every result pulse must match the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_res_valid", 32'd1, 32'd0);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          chk("sb_acc", 32'(bus.acc), 32'(e[W-1:0]));
          chk("sb_carry", 32'(bus.carry), 32'(e[W]));
        end
      end
    end
  end

  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_b     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_acc", 32'(bus.acc), 32'h0);
    chk("rst_carry", 32'(bus.carry), 32'h0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'h0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'h1);
    chk("rst_busy", 32'(bus.busy), 32'h0);

    // 1: load, then op 0
    send(1'b1, 3'd0, 8'h3C);
    send(1'b0, 3'd0, 8'h0F);
    chk("t1_acc", 32'(bus.acc), 32'hCF);
    chk("t1_rv", 32'(bus.res_valid), 32'h1);
    chk("t1_carry", 32'(bus.carry), 32'h0);
    @(posedge clk); #1;
    chk("t1_rv_drop", 32'(bus.res_valid), 32'h0);

    // 2: add with carry-out, then AND clears carry
    send(1'b1, 3'd0, 8'hF0);
    send(1'b0, 3'd4, 8'h20);
    chk("t2_add_acc", 32'(bus.acc), 32'h10);
    chk("t2_add_carry", 32'(bus.carry), 32'h1);
    send(1'b0, 3'd3, 8'hFF);
    chk("t2_and_acc", 32'(bus.acc), 32'h10);
    chk("t2_and_carry", 32'(bus.carry), 32'h0);

    // 3: popcount(A), with a load held pending during the scan
    send(1'b1, 3'd0, 8'hB5);
    send(1'b0, 3'd6, 8'h00);
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b1;
    bus.cmd_b     = 8'h99;
    for (int i = 0; i < 8; i++) begin
      chk("t3_ready_low", 32'(bus.cmd_ready), 32'h0);
      chk("t3_acc_hold", 32'(bus.acc), 32'hB5);
      @(posedge clk); #1;
    end
    chk("t3_ready_back", 32'(bus.cmd_ready), 32'h1);
    chk("t3_acc", 32'(bus.acc), 32'h05);
    chk("t3_rv", 32'(bus.res_valid), 32'h1);
    send(1'b1, 3'd0, 8'h99);
    chk("t3_pending_load", 32'(bus.acc), 32'h99);

    // 4: popcount(A)+popcount(B), twice
    send(1'b1, 3'd0, 8'hFF);
    send(1'b0, 3'd7, 8'h0F);
    chk("t4_busy", 32'(bus.busy), 32'h1);
    wait_ready(n);
    chk("t4_cycles", 32'(n), 32'd16);
    chk("t4_acc", 32'(bus.acc), 32'h0C);
    send(1'b0, 3'd7, 8'h00);
    wait_ready(n);
    chk("t4b_cycles", 32'(n), 32'd16);
    chk("t4b_acc", 32'(bus.acc), 32'h02);

    // 5: back-to-back single-cycle commands
    send(1'b1, 3'd0, 8'hAA);
    chk("t5_acc0", 32'(bus.acc), 32'hAA);
    chk("t5_rv0", 32'(bus.res_valid), 32'h1);
    send(1'b0, 3'd2, 8'h00);
    chk("t5_acc1", 32'(bus.acc), 32'h55);
    chk("t5_rv1", 32'(bus.res_valid), 32'h1);
    send(1'b0, 3'd5, 8'h00);
    chk("t5_acc2", 32'(bus.acc), 32'hAA);
    chk("t5_rv2", 32'(bus.res_valid), 32'h1);

    // 6: reset in the middle of a scan
    send(1'b1, 3'd0, 8'h0F);
    send(1'b0, 3'd6, 8'h00);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    exp_q.delete();
    model_acc = '0;
    chk("t6_acc", 32'(bus.acc), 32'h0);
    chk("t6_carry", 32'(bus.carry), 32'h0);
    chk("t6_ready", 32'(bus.cmd_ready), 32'h1);
    chk("t6_busy", 32'(bus.busy), 32'h0);
    chk("t6_rv", 32'(bus.res_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      chk("t6_no_rv", 32'(bus.res_valid), 32'h0);
    end
    send(1'b1, 3'd0, 8'h01);
    chk("t6_load", 32'(bus.acc), 32'h01);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
